// File: rtl/display_spi_rx.sv
// display_spi_rx: MAX7219-style serial receiver that fills digit and control registers; DISP_RX_DAISY_EN enables dout daisy chaining
module display_spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       dout,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] decode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown,
  output logic       test,
  output logic       frame_valid,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_err
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, cs_sync_q, cs_sync_d;
  logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] dig_q [8];
  logic [7:0] dig_d [8];
  logic [7:0] decode_q, decode_d, frame_data_q, frame_data_d;
  logic [3:0] intensity_q, intensity_d, frame_addr_q, frame_addr_d;
  logic [2:0] scan_limit_q, scan_limit_d;
  logic shutdown_q, shutdown_d, test_q, test_d;
  logic frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
  logic s_sclk, s_mosi, s_cs, sclk_rise, cs_rise, cs_fall, commit;
  assign s_sclk = sclk_sync_q[SYNC_STAGES-1];
  assign s_mosi = mosi_sync_q[SYNC_STAGES-1];
  assign s_cs = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~sclk_prev_q;
  assign cs_rise = s_cs & ~cs_prev_q;
  assign cs_fall = ~s_cs & cs_prev_q;
`ifdef DISP_RX_DAISY_EN
  logic dout_q, dout_d, sclk_fall;
  assign sclk_fall = ~s_sclk & sclk_prev_q;
  assign commit = cnt_q >= 5'd16;
  assign dout = dout_q;
  always_comb dout_d = (state_d == IDLE) ? 1'b0 : (sclk_fall ? shreg_q[15] : dout_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) dout_q <= 1'b0;
    else dout_q <= dout_d;
`else
  logic unused;
  assign unused = shreg_q[15];
  assign commit = cnt_q == 5'd16;
  assign dout = 1'b0;
`endif
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sclk_prev_d = s_sclk;
    cs_prev_d = s_cs;
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d = cnt_q;
    dig_d = dig_q;
    decode_d = decode_q;
    intensity_d = intensity_q;
    scan_limit_d = scan_limit_q;
    shutdown_d = shutdown_q;
    test_d = test_q;
    frame_addr_d = frame_addr_q;
    frame_data_d = frame_data_q;
    frame_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == IDLE) begin
      shreg_d = '0;
      cnt_d = '0;
      state_d = cs_fall ? SHIFT : IDLE;
    end else if (cs_rise) begin
      state_d = IDLE;
      frame_valid_d = commit;
      frame_err_d = ~commit;
      if (commit) begin
        frame_addr_d = shreg_q[11:8];
        frame_data_d = shreg_q[7:0];
        case (shreg_q[11:8])
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: dig_d[shreg_q[10:8] - 3'd1] = shreg_q[7:0];
          4'h9: decode_d = shreg_q[7:0];
          4'hA: intensity_d = shreg_q[3:0];
          4'hB: scan_limit_d = shreg_q[2:0];
          4'hC: shutdown_d = ~shreg_q[0];
          4'hF: test_d = shreg_q[0];
          default: ;
        endcase
      end
    end else if (sclk_rise) begin
      shreg_d = {shreg_q[14:0], s_mosi};
      cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
    end
  end
  // cs_n chain resets low so a cs_n already low at release never looks like a fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q <= 1'b0;
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q <= '0;
      dig_q <= '{default: '0};
      decode_q <= '0;
      intensity_q <= '0;
      scan_limit_q <= '0;
      shutdown_q <= 1'b1;
      test_q <= 1'b0;
      frame_addr_q <= '0;
      frame_data_q <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q <= cs_prev_d;
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      decode_q <= decode_d;
      intensity_q <= intensity_d;
      scan_limit_q <= scan_limit_d;
      shutdown_q <= shutdown_d;
      test_q <= test_d;
      frame_addr_q <= frame_addr_d;
      frame_data_q <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q <= frame_err_d;
    end
  assign rd_data = dig_q[rd_addr];
  assign decode = decode_q;
  assign intensity = intensity_q;
  assign scan_limit = scan_limit_q;
  assign shutdown = shutdown_q;
  assign test = test_q;
  assign frame_valid = frame_valid_q;
  assign frame_addr = frame_addr_q;
  assign frame_data = frame_data_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_display_spi_rx.sv
// tb_display_spi_rx: table-driven frame vectors plus reset and daisy-chain sequences
module tb_display_spi_rx;
  logic clk = 0, rst = 1, sclk = 0, mosi = 0, cs_n = 1, dout;
  logic [2:0] rd_addr = 0, scan_limit;
  logic [7:0] rd_data, decode, frame_data;
  logic [3:0] intensity, frame_addr;
  logic shutdown, test, frame_valid, frame_err;
  int total = 0, bad = 0, fv_n = 0, fe_n = 0, dout_hi = 0;
  logic [15:0] dcap = 0;
  display_spi_rx dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .dout(dout),
    .rd_addr(rd_addr), .rd_data(rd_data), .decode(decode), .intensity(intensity),
    .scan_limit(scan_limit), .shutdown(shutdown), .test(test), .frame_valid(frame_valid),
    .frame_addr(frame_addr), .frame_data(frame_data), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_valid) fv_n++;
    if (frame_err) fe_n++;
    if (dout) dout_hi++;
  end
  typedef struct {
    logic [31:0] frame;
    int nbits;
    int exp_v;
    int exp_e;
    logic [3:0] addr;
    logic [7:0] data;
    logic [2:0] ra;
    logic [7:0] rd;
    logic [16:0] ctrl;
  } vec_t;
  vec_t v[17];
  task automatic w(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic shift(input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      w(4);
      if (n - i > 16) dcap = {dcap[14:0], dout};
      sclk = 1;
      w(4);
      sclk = 0;
      w(4);
    end
  endtask
  task automatic frame(input logic [31:0] d, input int n);
    cs_n = 0;
    w(4);
    shift(d, n);
    cs_n = 1;
    w(8);
  endtask
  function automatic logic [16:0] ctl();
    return {decode, intensity, scan_limit, shutdown, test};
  endfunction
  initial begin
    int fv0, fe0;
    v[0]  = '{32'h0305, 16, 1, 0, 4'h3, 8'h05, 3'd2, 8'h05, {8'h00, 4'h0, 3'd0, 1'b1, 1'b0}};
    v[1]  = '{32'h0C01, 16, 1, 0, 4'hC, 8'h01, 3'd2, 8'h05, {8'h00, 4'h0, 3'd0, 1'b0, 1'b0}};
    v[2]  = '{32'h0A1F, 16, 1, 0, 4'hA, 8'h1F, 3'd2, 8'h05, {8'h00, 4'hF, 3'd0, 1'b0, 1'b0}};
    v[3]  = '{32'h0B03, 16, 1, 0, 4'hB, 8'h03, 3'd3, 8'h00, {8'h00, 4'hF, 3'd3, 1'b0, 1'b0}};
    v[4]  = '{32'h09FF, 16, 1, 0, 4'h9, 8'hFF, 3'd2, 8'h05, {8'hFF, 4'hF, 3'd3, 1'b0, 1'b0}};
    v[5]  = '{32'h0F01, 16, 1, 0, 4'hF, 8'h01, 3'd0, 8'h00, {8'hFF, 4'hF, 3'd3, 1'b0, 1'b1}};
    v[6]  = '{32'h01A5, 16, 1, 0, 4'h1, 8'hA5, 3'd0, 8'hA5, {8'hFF, 4'hF, 3'd3, 1'b0, 1'b1}};
    v[7]  = '{32'hF2C3, 16, 1, 0, 4'h2, 8'hC3, 3'd1, 8'hC3, {8'hFF, 4'hF, 3'd3, 1'b0, 1'b1}};
    v[8]  = '{32'h0D77, 16, 1, 0, 4'hD, 8'h77, 3'd1, 8'hC3, {8'hFF, 4'hF, 3'd3, 1'b0, 1'b1}};
    v[9]  = '{32'h0000, 16, 1, 0, 4'h0, 8'h00, 3'd0, 8'hA5, {8'hFF, 4'hF, 3'd3, 1'b0, 1'b1}};
    v[10] = '{32'h0123, 12, 0, 1, 4'h0, 8'h00, 3'd0, 8'hA5, {8'hFF, 4'hF, 3'd3, 1'b0, 1'b1}};
    v[11] = '{32'h0C00, 16, 1, 0, 4'hC, 8'h00, 3'd1, 8'hC3, {8'hFF, 4'hF, 3'd3, 1'b1, 1'b1}};
    v[12] = '{32'h0F00, 16, 1, 0, 4'hF, 8'h00, 3'd1, 8'hC3, {8'hFF, 4'hF, 3'd3, 1'b1, 1'b0}};
    v[13] = '{32'h0B07, 16, 1, 0, 4'hB, 8'h07, 3'd1, 8'hC3, {8'hFF, 4'hF, 3'd7, 1'b1, 1'b0}};
    v[14] = '{32'h0801, 16, 1, 0, 4'h8, 8'h01, 3'd7, 8'h01, {8'hFF, 4'hF, 3'd7, 1'b1, 1'b0}};
    v[15] = '{32'h0A38, 16, 1, 0, 4'hA, 8'h38, 3'd7, 8'h01, {8'hFF, 4'h8, 3'd7, 1'b1, 1'b0}};
    v[16] = '{32'h0E5A, 16, 1, 0, 4'hE, 8'h5A, 3'd2, 8'h05, {8'hFF, 4'h8, 3'd7, 1'b1, 1'b0}};
    w(4);
    rst = 0;
    w(8);
    chk("reset ctrl", ctl(), {8'h00, 4'h0, 3'd0, 1'b1, 1'b0});
    chk("reset frame", {frame_addr, frame_data, frame_valid, frame_err, dout}, 0);
    chk("reset pulses", fv_n + fe_n, 0);
    for (int a = 0; a < 8; a++) begin
      rd_addr = a[2:0];
      #1 chk($sformatf("reset rd%0d", a), rd_data, 0);
    end
    for (int i = 0; i < 17; i++) begin
      fv0 = fv_n;
      fe0 = fe_n;
      frame(v[i].frame, v[i].nbits);
      rd_addr = v[i].ra;
      #1;
      chk($sformatf("v%0d valid", i), fv_n - fv0, v[i].exp_v);
      chk($sformatf("v%0d err", i), fe_n - fe0, v[i].exp_e);
      chk($sformatf("v%0d addr", i), frame_addr, v[i].addr);
      chk($sformatf("v%0d data", i), frame_data, v[i].data);
      chk($sformatf("v%0d rd", i), rd_data, v[i].rd);
      chk($sformatf("v%0d ctrl", i), ctl(), v[i].ctrl);
      if (i == 0)
        for (int a = 0; a < 8; a++) begin
          rd_addr = a[2:0];
          #1 chk($sformatf("v0 rd%0d", a), rd_data, a == 2 ? 8'h05 : 8'h00);
        end
    end
    // reset mid-frame with cs_n held low through release
    cs_n = 0;
    w(4);
    shift(32'h00AB, 8);
    rst = 1;
    w(3);
    rst = 0;
    w(8);
    fv0 = fv_n;
    fe0 = fe_n;
    shift(32'h0599, 16);
    cs_n = 1;
    w(8);
    rd_addr = 4;
    #1;
    chk("lowcs valid", fv_n - fv0, 0);
    chk("lowcs err", fe_n - fe0, 0);
    chk("lowcs rd4", rd_data, 0);
    chk("mid rst ctrl", ctl(), {8'h00, 4'h0, 3'd0, 1'b1, 1'b0});
    frame(32'h0811, 16);
    rd_addr = 7;
    #1;
    chk("after rst rd7", rd_data, 8'h11);
    chk("after rst valid", fv_n - fv0, 1);
    chk("after rst err", fe_n - fe0, 0);
    rd_addr = 0;
    #1 chk("after rst rd0", rd_data, 0);
    fv0 = fv_n;
    fe0 = fe_n;
    dout_hi = 0;
    frame(32'h0142_0299, 32);
    rd_addr = 1;
    #1;
`ifdef DISP_RX_DAISY_EN
    chk("daisy valid", fv_n - fv0, 1);
    chk("daisy err", fe_n - fe0, 0);
    chk("daisy rd1", rd_data, 8'h99);
    chk("daisy addr", frame_addr, 4'h2);
    chk("daisy dout", dcap, 16'h0142);
    chk("daisy dout idle", dout, 0);
`else
    chk("long valid", fv_n - fv0, 0);
    chk("long err", fe_n - fe0, 1);
    chk("long rd1", rd_data, 0);
    chk("long addr", frame_addr, 4'h8);
    chk("long dout", dout_hi, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
